rf_operand_fetch: RTL and testbench
===================================

// Module: rf_operand_fetch
// PURPOSE
//  Read-side companion of the 2R1W sync register file: decode-to-execute operand-fetch stage.
//  Accepts rs1/rs2 + payload from decode, issues the regfile read, and absorbs its 1-cycle latency.
//  Holds operands across execute back-pressure and forwards writeback data the regfile cannot yet return.
//  Presents one operand-complete entry to execute with valid/ready.
// PARAMETERS
//  width_p          32  operand/data width
//  addr_width_p      5  register index width (32 registers, x0 hardwired zero)
//  payload_width_p  64  opaque decode payload (pc, ctrl) passed alongside
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  flush_i        in   1   synchronous kill of held entry and of same-cycle accept
//  id_v_i         in   1   decode request valid
//  id_ready_o     out  1   stage can accept
//  id_rs1_i       in   A   source reg 1 index
//  id_rs2_i       in   A   source reg 2 index
//  id_payload_i   in   P   payload
//  rf_rv_o        out  1   regfile read enable (drives both read ports)
//  rf_rs1_o       out  A   regfile read addr 0
//  rf_rs2_o       out  A   regfile read addr 1
//  rf_rd1_i       in   W   regfile read data 0, valid cycle after rf_rv_o
//  rf_rd2_i       in   W   regfile read data 1
//  wb_v_i         in   1   writeback valid (same signal feeding regfile write)
//  wb_rd_i        in   A   writeback index
//  wb_data_i      in   W   writeback data
//  ex_v_o         out  1   operands valid to execute
//  ex_ready_i     in   1   execute accepts
//  ex_rs1_data_o  out  W   operand 1
//  ex_rs2_data_o  out  W   operand 2
//  ex_payload_o   out  P   payload
// BEHAVIOUR
//  - Reset (async): slot EMPTY; ex_v_o=0, rf_rv_o=0, id_ready_o=1; data regs cleared to 0.
//  - One-entry slot, states EMPTY / FRESH / HELD.
//  - id_ready_o = (state==EMPTY) | ex_ready_i; accept = id_v_i & id_ready_o & ~flush_i.
//  - rf_rv_o = accept; rf_rs1_o/rf_rs2_o = id_rs1_i/id_rs2_i (combinational).
//  - accept -> FRESH next cycle; latch rs indices + payload.
//  - FRESH, ex_ready_i=0 -> HELD; resolved operands captured (regfile output undefined once rv drops).
//  - FRESH/HELD, ex_ready_i=1 -> FRESH if accept, else EMPTY.
//  - flush_i: next state EMPTY, no accept that cycle; overrides everything but reset.
//  - Accept-cycle hazard: wb_v_i & wb_rd_i==rsN & rsN!=0 in the accept cycle latches wb_data_i into bypN + flag.
//    Reason: regfile same-address read-during-write data is not relied upon.
//  - Operand resolve, per N, highest priority first:
//      1. rsN==0 -> 0
//      2. wb_v_i & wb_rd_i==rsN this cycle -> wb_data_i
//      3. FRESH: bypN if flag, else rf_rdN_i
//      4. HELD: captured value
//  - HELD: a matching wb write also updates the captured value; a stalled entry never goes stale.
//  - Latency: accept at cycle t -> ex_v_o at t+1; full throughput, 1 entry/cycle under ex_ready_i=1.
//  - wb_rd_i==0 writes are never forwarded.
//  - Reset mid-operation drops the entry; no output glitch obligations.
// STRUCTURE
//  - rf_pkg: reg_addr_t (logic [4:0]), word_t, fetch_state_e {EMPTY,FRESH,HELD}, REG_ZERO constant.
//  - Sub-module rf_operand_resolve: combinational per-operand priority mux.
//    Instantiated twice (rs1, rs2); FSM, capture and bypass regs stay in top.
// TESTING
//  1. Reset mid-stream: reset asserted with entry FRESH -> ex_v_o=0 immediately, id_ready_o=1.
//  2. Back-to-back, no hazards: rs1=3, rs2=4 (rf holds 0x11, 0x22), ex_ready=1 -> ex data 0x11/0x22 at t+1.
//     Next accept follows every cycle.
//  3. Accept-cycle bypass: accept rs1=5 while wb x5<=0xDEAD -> ex_rs1_data=0xDEAD at t+1.
//     Holds even if rf returns garbage.
//  4. Stall + late write: entry rs2=7 stalled 3 cycles, wb x7<=0xBEEF in stall cycle 2.
//     -> ex_rs2_data=0xBEEF from that cycle on, after release too.
//  5. x0 handling: rs1=0, wb x0<=0xFFFF same cycle -> ex_rs1_data=0; regfile not relied upon.
//  6. Flush: flush_i with id_v_i=1 and entry HELD -> next cycle ex_v_o=0, rf_rv_o=0 in flush cycle.

Source files
------------

// File: rtl/rf_operand_fetch_pkg.sv
// Shared types and defaults for the decode-to-execute operand-fetch stage.
package rf_operand_fetch_pkg;

  localparam int WIDTH_P         = 32;
  localparam int ADDR_WIDTH_P    = 5;
  localparam int PAYLOAD_WIDTH_P = 64;

  typedef logic [ADDR_WIDTH_P-1:0] reg_addr_t;
  typedef logic [WIDTH_P-1:0]      word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_operand_fetch_if.sv
// Bundles the decode, regfile-read, writeback and execute signals of the operand-fetch stage.
interface rf_operand_fetch_if
  import rf_operand_fetch_pkg::*;
#(
  parameter int width_p         = WIDTH_P,
  parameter int addr_width_p    = ADDR_WIDTH_P,
  parameter int payload_width_p = PAYLOAD_WIDTH_P
) ();

  logic                       flush_i;
  logic                       id_v_i;
  logic                       id_ready_o;
  logic [addr_width_p-1:0]    id_rs1_i;
  logic [addr_width_p-1:0]    id_rs2_i;
  logic [payload_width_p-1:0] id_payload_i;
  logic                       rf_rv_o;
  logic [addr_width_p-1:0]    rf_rs1_o;
  logic [addr_width_p-1:0]    rf_rs2_o;
  logic [width_p-1:0]         rf_rd1_i;
  logic [width_p-1:0]         rf_rd2_i;
  logic                       wb_v_i;
  logic [addr_width_p-1:0]    wb_rd_i;
  logic [width_p-1:0]         wb_data_i;
  logic                       ex_v_o;
  logic                       ex_ready_i;
  logic [width_p-1:0]         ex_rs1_data_o;
  logic [width_p-1:0]         ex_rs2_data_o;
  logic [payload_width_p-1:0] ex_payload_o;

  modport slave (
    input  flush_i, id_v_i, id_rs1_i, id_rs2_i, id_payload_i,
    input  rf_rd1_i, rf_rd2_i, wb_v_i, wb_rd_i, wb_data_i, ex_ready_i,
    output id_ready_o, rf_rv_o, rf_rs1_o, rf_rs2_o,
    output ex_v_o, ex_rs1_data_o, ex_rs2_data_o, ex_payload_o
  );

  modport master (
    output flush_i, id_v_i, id_rs1_i, id_rs2_i, id_payload_i,
    output rf_rd1_i, rf_rd2_i, wb_v_i, wb_rd_i, wb_data_i, ex_ready_i,
    input  id_ready_o, rf_rv_o, rf_rs1_o, rf_rs2_o,
    input  ex_v_o, ex_rs1_data_o, ex_rs2_data_o, ex_payload_o
  );

endinterface

// File: rtl/rf_operand_fetch_resolve.sv
// Per-operand priority mux: x0, live writeback, then regfile/bypass (FRESH) or captured value (HELD).
module rf_operand_fetch_resolve
  import rf_operand_fetch_pkg::*;
#(
  parameter int width_p      = WIDTH_P,
  parameter int addr_width_p = ADDR_WIDTH_P
) (
  input  logic [addr_width_p-1:0] i_rs,
  input  logic                    i_wb_v,
  input  logic [addr_width_p-1:0] i_wb_rd,
  input  logic [width_p-1:0]      i_wb_data,
  input  logic                    i_fresh,
  input  logic                    i_byp_v,
  input  logic [width_p-1:0]      i_byp,
  input  logic [width_p-1:0]      i_rf_rd,
  input  logic [width_p-1:0]      i_cap,
  output logic [width_p-1:0]      o_data
);

  always_comb begin
    o_data = i_cap;
    if (i_rs == addr_width_p'(REG_ZERO)) begin
      o_data = '0;
    end else if (i_wb_v && (i_wb_rd == i_rs)) begin
      o_data = i_wb_data;
    end else if (i_fresh) begin
      o_data = i_byp_v ? i_byp : i_rf_rd;
    end
  end

endmodule

// File: rtl/rf_operand_fetch.sv
// One-entry operand-fetch slot between decode and execute: issues the regfile read,
// absorbs its one-cycle latency, and keeps stalled operands current with writeback.
module rf_operand_fetch
  import rf_operand_fetch_pkg::*;
#(
  parameter int width_p         = WIDTH_P,
  parameter int addr_width_p    = ADDR_WIDTH_P,
  parameter int payload_width_p = PAYLOAD_WIDTH_P
) (
  input  logic              clk,
  input  logic              reset,
  rf_operand_fetch_if.slave bus
);

  fetch_state_e               r_state;
  fetch_state_e               w_state_nxt;
  logic                       w_occupied;
  logic                       w_accept;
  logic                       w_hold;
  logic                       w_hit1;
  logic                       w_hit2;
  logic [addr_width_p-1:0]    r_rs1;
  logic [addr_width_p-1:0]    r_rs2;
  logic [payload_width_p-1:0] r_payload;
  logic [width_p-1:0]         r_byp1;
  logic [width_p-1:0]         r_byp2;
  logic                       r_byp1_v;
  logic                       r_byp2_v;
  logic [width_p-1:0]         r_cap1;
  logic [width_p-1:0]         r_cap2;
  logic [width_p-1:0]         w_op1;
  logic [width_p-1:0]         w_op2;

  assign w_occupied = (r_state != EMPTY);
  assign w_accept   = bus.id_v_i & bus.id_ready_o & ~bus.flush_i;
  assign w_hold     = w_occupied & ~bus.ex_ready_i & ~bus.flush_i;

  // The regfile's same-address read-during-write result is not trusted, so catch it here.
  assign w_hit1 = bus.wb_v_i & (bus.wb_rd_i == bus.id_rs1_i) & (bus.id_rs1_i != addr_width_p'(REG_ZERO));
  assign w_hit2 = bus.wb_v_i & (bus.wb_rd_i == bus.id_rs2_i) & (bus.id_rs2_i != addr_width_p'(REG_ZERO));

  assign bus.id_ready_o    = ~w_occupied | bus.ex_ready_i;
  assign bus.rf_rv_o       = w_accept;
  assign bus.rf_rs1_o      = bus.id_rs1_i;
  assign bus.rf_rs2_o      = bus.id_rs2_i;
  assign bus.ex_v_o        = w_occupied;
  assign bus.ex_rs1_data_o = w_op1;
  assign bus.ex_rs2_data_o = w_op2;
  assign bus.ex_payload_o  = r_payload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = EMPTY;
    end else if (!w_occupied || bus.ex_ready_i) begin
      w_state_nxt = w_accept ? FRESH : EMPTY;
    end else begin
      w_state_nxt = HELD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_payload <= '0;
      r_byp1    <= '0;
      r_byp2    <= '0;
      r_byp1_v  <= 1'b0;
      r_byp2_v  <= 1'b0;
      r_cap1    <= '0;
      r_cap2    <= '0;
    end else begin
      if (w_accept) begin
        r_rs1     <= bus.id_rs1_i;
        r_rs2     <= bus.id_rs2_i;
        r_payload <= bus.id_payload_i;
        r_byp1_v  <= w_hit1;
        r_byp2_v  <= w_hit2;
        r_byp1    <= bus.wb_data_i;
        r_byp2    <= bus.wb_data_i;
      end
      // Re-capturing the resolved value every stalled cycle folds in any matching writeback.
      if (w_hold) begin
        r_cap1 <= w_op1;
        r_cap2 <= w_op2;
      end
    end
  end

  rf_operand_fetch_resolve #(.width_p(width_p), .addr_width_p(addr_width_p)) u_res1 (
    .i_rs      (r_rs1),
    .i_wb_v    (bus.wb_v_i),
    .i_wb_rd   (bus.wb_rd_i),
    .i_wb_data (bus.wb_data_i),
    .i_fresh   (r_state == FRESH),
    .i_byp_v   (r_byp1_v),
    .i_byp     (r_byp1),
    .i_rf_rd   (bus.rf_rd1_i),
    .i_cap     (r_cap1),
    .o_data    (w_op1)
  );

  rf_operand_fetch_resolve #(.width_p(width_p), .addr_width_p(addr_width_p)) u_res2 (
    .i_rs      (r_rs2),
    .i_wb_v    (bus.wb_v_i),
    .i_wb_rd   (bus.wb_rd_i),
    .i_wb_data (bus.wb_data_i),
    .i_fresh   (r_state == FRESH),
    .i_byp_v   (r_byp2_v),
    .i_byp     (r_byp2),
    .i_rf_rd   (bus.rf_rd2_i),
    .i_cap     (r_cap2),
    .o_data    (w_op2)
  );

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Scoreboard bench for rf_operand_fetch: architectural register model plus a regfile that
// returns garbage for x0 and same-address read-during-write.
module tb_rf_operand_fetch;
  import rf_operand_fetch_pkg::*;

  localparam int W = 32;
  localparam int A = 5;
  localparam int P = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_operand_fetch_if #(.width_p(W), .addr_width_p(A), .payload_width_p(P)) bus ();

  rf_operand_fetch #(.width_p(W), .addr_width_p(A), .payload_width_p(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic [P-1:0] pl;
    int unsigned  cyc;
  } entry_t;

  entry_t      q[$];
  int unsigned cyc = 0;
  logic [W-1:0] arch [32];
  int checks   = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rf_read(input logic [A-1:0] a);
    if (a == 0 || (bus.wb_v_i && bus.wb_rd_i == a)) return W'($urandom);
    return arch[a];
  endfunction

  // Value of register rs as execute should see it right now: architectural state plus live write.
  function automatic logic [W-1:0] ref_op(input logic [A-1:0] rs);
    if (rs == 0) return '0;
    if (bus.wb_v_i && bus.wb_rd_i == rs) return bus.wb_data_i;
    return arch[rs];
  endfunction

  function automatic bit presented();
    return (q.size() > 0) && (q[0].cyc < cyc);
  endfunction

  // Regfile: sync read, one-cycle latency; x0 and collisions return junk.
  initial begin
    for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? '0 : W'($urandom);
    arch[3] = 32'h11;
    arch[4] = 32'h22;
    bus.rf_rd1_i = '0;
    bus.rf_rd2_i = '0;
    forever begin
      @(posedge clk);
      if (bus.rf_rv_o) begin
        bus.rf_rd1_i <= rf_read(bus.rf_rs1_o);
        bus.rf_rd2_i <= rf_read(bus.rf_rs2_o);
      end
      if (bus.wb_v_i && bus.wb_rd_i != 0) arch[bus.wb_rd_i] <= bus.wb_data_i;
    end
  end

  // Monitor
  initial begin
    bit pres;
    bit exp_ready;
    bit exp_rv;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        chk("rst_ex_v", 64'(bus.ex_v_o), 64'd0);
        chk("rst_id_ready", 64'(bus.id_ready_o), 64'd1);
      end else begin
        pres      = presented();
        exp_ready = !pres || bus.ex_ready_i;
        exp_rv    = bus.id_v_i && exp_ready && !bus.flush_i;
        chk("ex_v", 64'(bus.ex_v_o), 64'(pres));
        chk("id_ready", 64'(bus.id_ready_o), 64'(exp_ready));
        chk("rf_rv", 64'(bus.rf_rv_o), 64'(exp_rv));
        if (exp_rv) begin
          chk("rf_rs1", 64'(bus.rf_rs1_o), 64'(bus.id_rs1_i));
          chk("rf_rs2", 64'(bus.rf_rs2_o), 64'(bus.id_rs2_i));
        end
        if (pres) begin
          chk("ex_rs1_data", 64'(bus.ex_rs1_data_o), 64'(ref_op(q[0].rs1)));
          chk("ex_rs2_data", 64'(bus.ex_rs2_data_o), 64'(ref_op(q[0].rs2)));
          chk("ex_payload", bus.ex_payload_o, q[0].pl);
          if (bus.ex_ready_i || bus.flush_i) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic rst_v, input logic v, input logic [A-1:0] r1, input logic [A-1:0] r2,
                      input logic wbv, input logic [A-1:0] wbrd, input logic [W-1:0] wbd,
                      input logic exr, input logic fl);
    logic [P-1:0] pl;
    @(posedge clk);
    #1;
    pl               = {$urandom, $urandom};
    reset            = rst_v;
    bus.id_v_i       = v && !rst_v;
    bus.id_rs1_i     = r1;
    bus.id_rs2_i     = r2;
    bus.id_payload_i = pl;
    bus.wb_v_i       = wbv;
    bus.wb_rd_i      = wbrd;
    bus.wb_data_i    = wbd;
    bus.ex_ready_i   = exr;
    bus.flush_i      = fl;
    if (!rst_v && v && (!presented() || exr) && !fl)
      q.push_back('{rs1: r1, rs2: r2, pl: pl, cyc: cyc});
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush_i = 1'b0; bus.id_v_i = 1'b0; bus.id_rs1_i = '0; bus.id_rs2_i = '0;
    bus.id_payload_i = '0; bus.wb_v_i = 1'b0; bus.wb_rd_i = '0; bus.wb_data_i = '0;
    bus.ex_ready_i = 1'b0;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset with an entry FRESH
    step(0, 1, 3, 4, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_ex_v", 64'(bus.ex_v_o), 64'd0);
    chk("t1_id_ready", 64'(bus.id_ready_o), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Back-to-back without hazards
    step(0, 1, 3, 4, 0, 0, 0, 1, 0);
    step(0, 1, 3, 4, 0, 0, 0, 1, 0);
    chk("t2_rs1", 64'(bus.ex_rs1_data_o), 64'h11);
    chk("t2_rs2", 64'(bus.ex_rs2_data_o), 64'h22);
    chk("t2_rv", 64'(bus.rf_rv_o), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_rs1_b", 64'(bus.ex_rs1_data_o), 64'h11);

    // Accept-cycle bypass
    step(0, 1, 5, 6, 1, 5, 32'hDEAD, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_rs1", 64'(bus.ex_rs1_data_o), 64'hDEAD);

    // Stall with late write
    step(0, 1, 1, 7, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 32'hBEEF, 0, 0);
    chk("t4_rs2_wb", 64'(bus.ex_rs2_data_o), 64'hBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_rs2_held", 64'(bus.ex_rs2_data_o), 64'hBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_rs2_rel", 64'(bus.ex_rs2_data_o), 64'hBEEF);

    // x0 with a same-cycle write to x0
    step(0, 1, 0, 2, 1, 0, 32'hFFFF, 1, 0);
    step(0, 0, 0, 0, 1, 0, 32'hFFFF, 1, 0);
    chk("t5_rs1", 64'(bus.ex_rs1_data_o), 64'd0);

    // Flush while HELD with a new request
    step(0, 1, 8, 9, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 10, 11, 0, 0, 0, 0, 1);
    chk("t6_rv", 64'(bus.rf_rv_o), 64'd0);
    chk("t6_ex_v_before", 64'(bus.ex_v_o), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_ex_v_after", 64'(bus.ex_v_o), 64'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7,
           A'($urandom_range(0, 7)), A'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, A'($urandom_range(0, 7)), W'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
